// File: rtl/regfifo_param.sv
// regfifo_param: parametrised register-based first-word-fall-through FIFO.
// Entry 0 is always the head, so dout needs no read pointer. Occupancy is a
// binary counter, and full/empty/almost_full are decoded from it.
// Optional macro REGFIFO_ERR_FLAG_EN enables the sticky overflow/underflow
// flags and err_clr. When the macro is undefined, both flags are tied to 0
// and err_clr is ignored.
module regfifo_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
    assign push_ok = wr_en & (~full | rd_en);
    assign pop_ok  = rd_en & ~empty;

    assign full        = (cnt == CNT_W'(DEPTH));
    assign empty       = (cnt == '0);
    assign almost_full = (cnt >= CNT_W'(AFULL_TH));
    assign count       = cnt;
    assign dout        = mem[0];

    // The storage shifts toward the head on a pop. A push lands just past the
    // last valid entry, one slot lower if a pop happens in the same cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (push_ok && (i == int'(cnt) - 1)) begin
                    mem[i] <= din;
                end else begin
                    mem[i] <= mem[i+1];
                end
            end
            if (push_ok && (DEPTH - 1 == int'(cnt) - 1)) begin
                mem[DEPTH-1] <= din;
            end else begin
                mem[DEPTH-1] <= '0;
            end
        end else if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(cnt)) begin
                    mem[i] <= din;
                end
            end
        end
    end

    // The counter moves only when exactly one of push and pop is accepted, so it stays within 0..DEPTH.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt <= '0;
        end else if (push_ok && !pop_ok) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifdef REGFIFO_ERR_FLAG_EN
    logic ovf_event;
    logic unf_event;

    // An overflow event is a dropped write. An underflow event is a read while empty, even if a write is accepted.
    assign ovf_event = wr_en & full & ~rd_en;
    assign unf_event = rd_en & empty;

    // The flags are sticky. A new event wins over err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_event | (overflow & ~err_clr);
            underflow <= unf_event | (underflow & ~err_clr);
        end
    end
`else
    logic err_clr_unused;

    assign err_clr_unused = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_regfifo_param.sv
// tb_regfifo_param: directed table-driven checks on the default 32x4 FIFO,
// plus scoreboard-checked random traffic on DEPTH=2 and DEPTH=16 variants.
module tb_regfifo_param;

`ifdef REGFIFO_ERR_FLAG_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main DUT: WIDTH=32, DEPTH=4, AFULL_TH=3.
    logic        srst, wr_en, rd_en, err_clr;
    logic [31:0] din, dout;
    logic        full, empty, almost_full, overflow, underflow;
    logic [2:0]  count;

    regfifo_param #(.WIDTH(32), .DEPTH(4), .AFULL_TH(3)) dut (
        .clk(clk), .srst(srst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    // Variant B: WIDTH=32, DEPTH=2, AFULL_TH=2.
    logic        b_wr, b_rd;
    logic [31:0] b_din, b_dout;
    logic        b_full, b_empty, b_af, b_ovf, b_unf;
    logic [1:0]  b_count;

    regfifo_param #(.WIDTH(32), .DEPTH(2), .AFULL_TH(2)) dut_b (
        .clk(clk), .srst(srst), .wr_en(b_wr), .din(b_din), .rd_en(b_rd),
        .dout(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf), .err_clr(1'b0)
    );

    // Variant C: WIDTH=8, DEPTH=16, AFULL_TH=12.
    logic       c_wr, c_rd;
    logic [7:0] c_din, c_dout;
    logic       c_full, c_empty, c_af, c_ovf, c_unf;
    logic [4:0] c_count;

    regfifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12)) dut_c (
        .clk(clk), .srst(srst), .wr_en(c_wr), .din(c_din), .rd_en(c_rd),
        .dout(c_dout), .full(c_full), .empty(c_empty), .almost_full(c_af),
        .count(c_count), .overflow(c_ovf), .underflow(c_unf), .err_clr(1'b0)
    );

    typedef struct {
        logic        srst;
        logic        wr;
        logic        rd;
        logic        clr;
        logic [31:0] din;
        logic [31:0] e_dout;
        int          e_cnt;
        logic        e_full;
        logic        e_empty;
        logic        e_af;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic w, input logic r,
                                 input logic c, input logic [31:0] d);
        srst    = s;
        wr_en   = w;
        rd_en   = r;
        err_clr = c;
        din     = d;
        @(posedge clk);
        #1;
        srst    = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic checkMain(input string tag, input logic [31:0] e_dout, input int e_cnt,
                             input logic e_full, input logic e_empty, input logic e_af,
                             input logic e_ovf, input logic e_unf);
        checkOutput({tag, " dout"},  dout, e_dout);
        checkOutput({tag, " count"}, 32'(count), 32'(e_cnt));
        checkOutput({tag, " full"},  32'(full), 32'(e_full));
        checkOutput({tag, " empty"}, 32'(empty), 32'(e_empty));
        checkOutput({tag, " afull"}, 32'(almost_full), 32'(e_af));
        checkOutput({tag, " ovf"},   32'(overflow), 32'(e_ovf & FLAGS_ON));
        checkOutput({tag, " unf"},   32'(underflow), 32'(e_unf & FLAGS_ON));
    endtask

    initial begin
        logic [31:0] qb [$];
        logic [7:0]  qc [$];
        bit          pb, qpb, pc, qpc;

        srst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
        b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
        c_wr = 1'b0; c_rd = 1'b0; c_din = '0;

        // Fields: srst, wr, rd, clr, din | dout, count, full, empty, afull, ovf, unf
        vecs[0]  = '{1,0,0,0,32'h00, 32'h00, 0, 0,1,0, 0,0}; // reset
        vecs[1]  = '{0,1,0,0,32'hA0, 32'hA0, 1, 0,0,0, 0,0};
        vecs[2]  = '{0,1,0,0,32'hA1, 32'hA0, 2, 0,0,0, 0,0};
        vecs[3]  = '{0,1,0,0,32'hA2, 32'hA0, 3, 0,0,1, 0,0}; // almost_full at 3
        vecs[4]  = '{0,1,0,0,32'hA3, 32'hA0, 4, 1,0,1, 0,0}; // full
        vecs[5]  = '{0,1,1,0,32'hB0, 32'hA1, 4, 1,0,1, 0,0}; // full rd+wr: no loss
        vecs[6]  = '{0,1,0,0,32'hDD, 32'hA1, 4, 1,0,1, 1,0}; // overflow, dropped
        vecs[7]  = '{0,0,0,1,32'h00, 32'hA1, 4, 1,0,1, 0,0}; // err_clr
        vecs[8]  = '{0,1,0,1,32'hDE, 32'hA1, 4, 1,0,1, 1,0}; // event beats clear
        vecs[9]  = '{0,0,1,0,32'h00, 32'hA2, 3, 0,0,1, 1,0};
        vecs[10] = '{0,0,1,0,32'h00, 32'hA3, 2, 0,0,0, 1,0};
        vecs[11] = '{0,0,1,0,32'h00, 32'hB0, 1, 0,0,0, 1,0}; // tail was B0
        vecs[12] = '{0,0,1,0,32'h00, 32'h00, 0, 0,1,0, 1,0}; // dout 0 once empty
        vecs[13] = '{0,0,1,0,32'h00, 32'h00, 0, 0,1,0, 1,1}; // underflow
        vecs[14] = '{0,0,0,1,32'h00, 32'h00, 0, 0,1,0, 0,0};
        vecs[15] = '{0,1,1,0,32'hC0, 32'hC0, 1, 0,0,0, 0,1}; // empty rd+wr
        vecs[16] = '{0,1,0,0,32'hC1, 32'hC0, 2, 0,0,0, 0,1};
        vecs[17] = '{1,1,0,0,32'hEE, 32'h00, 0, 0,1,0, 0,0}; // reset wins over write
        vecs[18] = '{0,1,0,0,32'h11, 32'h11, 1, 0,0,0, 0,0};
        vecs[19] = '{0,0,0,0,32'h00, 32'h11, 1, 0,0,0, 0,0}; // hold
        vecs[20] = '{0,1,1,0,32'h22, 32'h22, 1, 0,0,0, 0,0}; // rd+wr at count 1

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].srst, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            checkMain($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_cnt, vecs[i].e_full,
                      vecs[i].e_empty, vecs[i].e_af, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Fill, then drain in order, watching the head before each pop.
        applyStimulus(1, 0, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 0, 32'hA0 + 32'(k));
            checkOutput($sformatf("fill%0d count", k), 32'(count), 32'(k + 1));
            checkOutput($sformatf("fill%0d dout", k), dout, 32'hA0);
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("drain%0d dout", k), dout, 32'hA0 + 32'(k));
            applyStimulus(0, 0, 1, 0, 32'h0);
        end
        checkMain("drained", 32'h0, 0, 0, 1, 0, 0, 0);

        // Random traffic on both variants against queue scoreboards.
        for (int n = 0; n < 3000; n++) begin
            b_wr  = 1'($urandom_range(0, 1));
            b_rd  = 1'($urandom_range(0, 1));
            b_din = $urandom;
            c_wr  = ($urandom_range(0, 9) < 6);
            c_rd  = ($urandom_range(0, 9) < 5);
            c_din = 8'($urandom);
            pb  = b_wr && ((qb.size() < 2) || b_rd);
            qpb = b_rd && (qb.size() > 0);
            pc  = c_wr && ((qc.size() < 16) || c_rd);
            qpc = c_rd && (qc.size() > 0);
            if (qpb) void'(qb.pop_front());
            if (pb) qb.push_back(b_din);
            if (qpc) void'(qc.pop_front());
            if (pc) qc.push_back(c_din);
            @(posedge clk);
            #1;
            checkOutput("B count", 32'(b_count), 32'(qb.size()));
            checkOutput("B dout", b_dout, (qb.size() > 0) ? qb[0] : 32'h0);
            checkOutput("B flags", {29'h0, b_full, b_empty, b_af},
                        {29'h0, qb.size() == 2, qb.size() == 0, qb.size() >= 2});
            checkOutput("C count", 32'(c_count), 32'(qc.size()));
            checkOutput("C dout", 32'(c_dout), (qc.size() > 0) ? 32'(qc[0]) : 32'h0);
            checkOutput("C flags", {29'h0, c_full, c_empty, c_af},
                        {29'h0, qc.size() == 16, qc.size() == 0, qc.size() >= 12});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
